// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM time-setting path.
// The state encoding is part of the debug interface (state_o), so it is fixed.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } set_state_t;

    localparam logic [4:0] HOUR_MAX_24 = 5'd23;
    localparam logic [4:0] HOUR_MAX_12 = 5'd12;
    localparam logic [4:0] HOUR_MIN_12 = 5'd1;
    localparam logic [5:0] MIN_MAX     = 6'd59;

    // Map a live counter hour into the editing range of the chosen format.
    // In 12 h format hour 0 reads as 12 and afternoon hours fold down by 12.
    function automatic logic [4:0] capture_hour(input logic [4:0] hour, input logic mil);
        logic [4:0] result;
        result = hour;
        if (!mil) begin
            if (hour == 5'd0) begin
                result = HOUR_MAX_12;
            end else if (hour > HOUR_MAX_12) begin
                result = hour - HOUR_MAX_12;
            end
        end
        return result;
    endfunction

    // One hour step with format-dependent wrap: 23 -> 0 (24 h), 12 -> 1 (12 h).
    function automatic logic [4:0] next_hour(input logic [4:0] hour, input logic mil);
        logic [4:0] result;
        result = hour + 5'd1;
        if (mil) begin
            if (hour == HOUR_MAX_24) begin
                result = 5'd0;
            end
        end else begin
            if (hour == HOUR_MAX_12) begin
                result = HOUR_MIN_12;
            end
        end
        return result;
    endfunction

    // One minute step, 59 -> 0; never carries into the hour.
    function automatic logic [5:0] next_min(input logic [5:0] min);
        logic [5:0] result;
        result = min + 6'd1;
        if (min == MIN_MAX) begin
            result = 6'd0;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability
// counter. The debounced level follows the raw input DEBOUNCE_MS+2 cycles
// after it settles; press is a one-cycle pulse on the debounced 0->1 edge,
// aligned with the level update.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 4
) (
    input  logic clk_1ms,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous button into the clk_1ms domain.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has differed from the current one for DEBOUNCE_MS cycles.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            level      <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_q2;
                press      <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Manual time-setting sequencer between the board buttons and the HH:MM
// counter. MODE walks RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN; INC (with
// auto-repeat) steps the field being edited, which blinks on the display.
// COMMIT issues a single-cycle load; an idle SET session times out to RUN
// without loading.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS  = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int BLINK_HALF   = 250,
    parameter int TIMEOUT_MS   = 10000
) (
    input  logic       clk_1ms,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       mil_time,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       run_en,
    output logic       load,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       blank_hour,
    output logic       blank_min,
    output logic [1:0] state_o
);

    // Repeat counter is shared by the initial delay and the repeat rate.
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int BW      = $clog2(BLINK_HALF + 1);
    localparam int TW      = $clog2(TIMEOUT_MS + 1);

    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_MS - 1);

    set_state_t    state;
    logic          mode_l;

    logic          mode_level;
    logic          mode_press;
    logic          inc_level;
    logic          inc_press;

    logic [RW-1:0] rep_cnt;
    logic          rep_active;
    logic          rep_fast;
    logic          rep_hold;
    logic          rep_tick;

    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic [TW-1:0] idle_cnt;
    logic          timeout;

    logic          in_set;
    logic          inc_step;
    logic          enter_set;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_db (
        .clk_1ms (clk_1ms),
        .reset_n (reset_n),
        .raw     (mode_btn),
        .level   (mode_level),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc_db (
        .clk_1ms (clk_1ms),
        .reset_n (reset_n),
        .raw     (inc_btn),
        .level   (inc_level),
        .press   (inc_press)
    );

    // Decode the events the FSM and counters react to; MODE always beats INC.
    always_comb begin
        in_set    = (state == SET_HR) || (state == SET_MIN);
        rep_hold  = in_set && inc_level && !mode_level;
        rep_tick  = rep_hold && rep_active &&
                    (rep_fast ? (rep_cnt == RATE_LAST) : (rep_cnt == DELAY_LAST));
        inc_step  = in_set && !mode_press && (inc_press || rep_tick);
        enter_set = mode_press && ((state == RUN) || (state == SET_HR));
        timeout   = in_set && (idle_cnt == IDLE_LAST);
    end

    // Main sequencer with registered run_en/load and the working time registers.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            state    <= RUN;
            mode_l   <= 1'b0;
            run_en   <= 1'b1;
            load     <= 1'b0;
            set_hour <= 5'd0;
            set_min  <= 6'd0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    run_en <= 1'b1;
                    if (mode_press) begin
                        mode_l   <= mil_time;
                        set_hour <= capture_hour(cur_hour, mil_time);
                        set_min  <= cur_min;
                        run_en   <= 1'b0;
                        state    <= SET_HR;
                    end
                end
                SET_HR: begin
                    if (mode_press) begin
                        state <= SET_MIN;
                    end else if (inc_step) begin
                        set_hour <= next_hour(set_hour, mode_l);
                    end else if (timeout) begin
                        run_en <= 1'b1;
                        state  <= RUN;
                    end
                end
                SET_MIN: begin
                    if (mode_press) begin
                        load  <= 1'b1;
                        state <= COMMIT;
                    end else if (inc_step) begin
                        set_min <= next_min(set_min);
                    end else if (timeout) begin
                        run_en <= 1'b1;
                        state  <= RUN;
                    end
                end
                COMMIT: begin
                    run_en <= 1'b1;
                    state  <= RUN;
                end
                default: begin
                    run_en <= 1'b1;
                    state  <= RUN;
                end
            endcase
        end
    end

    // Auto-repeat: armed only by an INC press inside a SET state, dropped on release or MODE.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_fast   <= 1'b0;
        end else if (!rep_hold || mode_press) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_fast   <= 1'b0;
        end else if (inc_press) begin
            rep_cnt    <= '0;
            rep_active <= 1'b1;
            rep_fast   <= 1'b0;
        end else if (rep_tick) begin
            rep_cnt  <= '0;
            rep_fast <= 1'b1;
        end else if (rep_active) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    // Blink phase: free-running, restarted visible on SET entry and on each step.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (enter_set || inc_step) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Idle timer: runs only inside a SET state and restarts on any button activity.
    always_ff @(posedge clk_1ms) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!in_set || mode_press || inc_press || rep_tick) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign blank_hour = (state == SET_HR) && phase;
    assign blank_min  = (state == SET_MIN) && phase;
    assign state_o    = state;

endmodule
